de_digital_clock: RTL and testbench
===================================

DE_DIGITAL_CLOCK -- requirements
Module: de_digital_clock

Interface
REQ-001 SHALL have ports: clk  in  1  timebase, one tick per rising edge (1 Hz, 1 s period).
REQ-002 SHALL have ports: r  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: s  in  1  time-set strobe; hour_24  in  1  display mode (1=24 h, 0=12 h).
REQ-004 SHALL have ports: a  in  3  hour tens; b  in  5  hour units; c  in  4  minute tens; d  in  5  minute units; e  in  4  second tens; f  in  5  second units (load value, 24 h format).
REQ-005 SHALL have ports: ain1  in  3  alarm hour tens; ain2  in  5  alarm hour units; ain3  in  4  alarm minute tens; ain4  in  5  alarm minute units (24 h format).
REQ-006 SHALL have ports: a_enable, a_reset, a_set  in  3 each  alarm arm / alarm clear / alarm load; each asserted when any bit is 1.
REQ-007 SHALL have ports: h1  out  3, h0  out  5, m1  out  4, m0  out  5, s1  out  4, s0  out  5  displayed BCD digits (tens/units).
REQ-008 SHALL have ports: am  out  1, pm  out  1  meridiem flags; a_out  out  1  alarm ringing.

Function
REQ-009 SHALL hold time internally as 24 h BCD hh:mm:ss; digit fields are zero-extended to port width.
REQ-010 SHALL, per clk edge with r=0 and s=0, advance time by one second: s0 9->0 carries to s1, s1 5->0 carries to m0, m 59->00 carries to hour, 23:59:59 -> 00:00:00.
REQ-011 SHALL, on an edge with s=1, load time from a..f instead of counting; load SHALL be rejected (time counts normally) if any field is out of range (hh>23, mm>59, ss>59, units>9).
REQ-012 SHALL, on an edge with a_set asserted, load alarm hh:mm from ain1..ain4; out-of-range alarm values SHALL be rejected (alarm register unchanged).
REQ-013 SHALL drive display outputs combinationally from the time register and hour_24.
REQ-014 SHALL, with hour_24=1, show hours 00..23 and drive am=pm=0.
REQ-015 SHALL, with hour_24=0, show hour 0 as 12, hours 13..23 as 01..11, hours 1..12 unchanged; am=1 when internal hour<12, else pm=1.
REQ-016 SHALL set a_out on the edge where the updated time equals alarm hh:mm:00 while a_enable is asserted (via counting or load).
REQ-017 SHALL hold a_out until a_reset is asserted or a_enable is deasserted; a_reset SHALL win over a simultaneous trigger.
REQ-018 SHALL apply priority r > s > count for time; r > a_set for the alarm register.

Reset
REQ-019 SHALL, on an edge with r=1, clear time to 00:00:00, alarm register to 00:00 and a_out to 0.
REQ-020 SHALL, after reset with hour_24=0, display 12:00:00 with am=1, pm=0; with hour_24=1, display 00:00:00 with am=pm=0.
REQ-021 SHALL apply reset mid-count or mid-alarm immediately on the next edge, overriding s, a_set and the trigger.

Configuration
REQ-022 SHALL compile a stopwatch only when DE_STOPWATCH_EN is defined; without it, no stopwatch ports or logic exist.
REQ-023 SHALL, with DE_STOPWATCH_EN, add ports start  in  1, pause  in  1, restart  in  1, count  out  32 (elapsed seconds).
REQ-024 SHALL, with DE_STOPWATCH_EN, on each edge: restart -> count=0 and stopped; else pause -> stopped, count held; else start -> running; when running, count increments by 1 and wraps at 2^32-1 -> 0; r clears count and stops.

Verification
REQ-025 SHALL cover: r=1 one edge, hour_24=0 -> 12:00:00, am=1, a_out=0.
REQ-026 SHALL cover: s=1 load 23:59:58, then 2 edges -> 23:59:59 then 00:00:00; with hour_24=0 shows 11:59:59 pm=1 then 12:00:00 am=1.
REQ-027 SHALL cover: s=1 load a=2,b=5 (hour 25) -> load rejected, time advances from prior value by 1 s.
REQ-028 SHALL cover: alarm set 07:30, a_enable=1, time loaded 07:29:59, one edge -> 07:30:00 and a_out=1; a_reset=1 one edge -> a_out=0.
REQ-029 SHALL cover: same alarm with a_enable=0 -> a_out stays 0; a_reset and trigger on same edge -> a_out=0.
REQ-030 SHALL cover (DE_STOPWATCH_EN): start 1 edge, 5 edges -> count=5; pause 3 edges -> count=5; restart -> count=0.

Source files
------------

// File: rtl/de_digital_clock.sv
// de_digital_clock: 24 h BCD time-of-day clock with load, 12/24 h display and alarm.
// Optional stopwatch (start/pause/restart, 32-bit seconds) is built only when DE_STOPWATCH_EN is defined.
`default_nettype none

module de_digital_clock (
   input  logic        clk,
   input  logic        r,
   input  logic        s,
   input  logic        hour_24,
   input  logic [2:0]  a,
   input  logic [4:0]  b,
   input  logic [3:0]  c,
   input  logic [4:0]  d,
   input  logic [3:0]  e,
   input  logic [4:0]  f,
   input  logic [2:0]  ain1,
   input  logic [4:0]  ain2,
   input  logic [3:0]  ain3,
   input  logic [4:0]  ain4,
   input  logic [2:0]  a_enable,
   input  logic [2:0]  a_reset,
   input  logic [2:0]  a_set,
`ifdef DE_STOPWATCH_EN
   input  logic        start,
   input  logic        pause,
   input  logic        restart,
   output logic [31:0] count,
`endif
   output logic [2:0]  h1,
   output logic [4:0]  h0,
   output logic [3:0]  m1,
   output logic [4:0]  m0,
   output logic [3:0]  s1,
   output logic [4:0]  s0,
   output logic        am,
   output logic        pm,
   output logic        a_out
);

   logic [1:0] hr_t, nx_hr_t, al_hr_t;
   logic [3:0] hr_u, nx_hr_u, al_hr_u;
   logic [2:0] mn_t, nx_mn_t, al_mn_t;
   logic [3:0] mn_u, nx_mn_u, al_mn_u;
   logic [2:0] sc_t, nx_sc_t;
   logic [3:0] sc_u, nx_sc_u;

   logic en_any, clr_any, set_any;
   logic load_ok, alarm_ok, trigger;

   assign en_any  = |a_enable;
   assign clr_any = |a_reset;
   assign set_any = |a_set;

   // Upper field bits are checked here, so truncating on load loses nothing.
   assign load_ok = s && (a <= 3'd2) && (b <= 5'd9) && !((a == 3'd2) && (b > 5'd3))
                      && (c <= 4'd5) && (d <= 5'd9) && (e <= 4'd5) && (f <= 5'd9);

   assign alarm_ok = (ain1 <= 3'd2) && (ain2 <= 5'd9) && !((ain1 == 3'd2) && (ain2 > 5'd3))
                     && (ain3 <= 4'd5) && (ain4 <= 5'd9);

   always_comb begin
      nx_hr_t = hr_t;
      nx_hr_u = hr_u;
      nx_mn_t = mn_t;
      nx_mn_u = mn_u;
      nx_sc_t = sc_t;
      nx_sc_u = sc_u;
      if (load_ok) begin
         nx_hr_t = a[1:0];
         nx_hr_u = b[3:0];
         nx_mn_t = c[2:0];
         nx_mn_u = d[3:0];
         nx_sc_t = e[2:0];
         nx_sc_u = f[3:0];
      end else if (sc_u != 4'd9) begin
         nx_sc_u = sc_u + 4'd1;
      end else begin
         nx_sc_u = 4'd0;
         if (sc_t != 3'd5) begin
            nx_sc_t = sc_t + 3'd1;
         end else begin
            nx_sc_t = 3'd0;
            if (mn_u != 4'd9) begin
               nx_mn_u = mn_u + 4'd1;
            end else begin
               nx_mn_u = 4'd0;
               if (mn_t != 3'd5) begin
                  nx_mn_t = mn_t + 3'd1;
               end else begin
                  nx_mn_t = 3'd0;
                  if ((hr_t == 2'd2) && (hr_u == 4'd3)) begin
                     nx_hr_t = 2'd0;
                     nx_hr_u = 4'd0;
                  end else if (hr_u == 4'd9) begin
                     nx_hr_u = 4'd0;
                     nx_hr_t = hr_t + 2'd1;
                  end else begin
                     nx_hr_u = hr_u + 4'd1;
                  end
               end
            end
         end
      end
   end

   // Match is against the time that will be visible after this edge.
   assign trigger = en_any && (nx_hr_t == al_hr_t) && (nx_hr_u == al_hr_u)
                    && (nx_mn_t == al_mn_t) && (nx_mn_u == al_mn_u)
                    && (nx_sc_t == 3'd0) && (nx_sc_u == 4'd0);

   always_ff @(posedge clk) begin
      if (r) begin
         hr_t    <= 2'd0;
         hr_u    <= 4'd0;
         mn_t    <= 3'd0;
         mn_u    <= 4'd0;
         sc_t    <= 3'd0;
         sc_u    <= 4'd0;
         al_hr_t <= 2'd0;
         al_hr_u <= 4'd0;
         al_mn_t <= 3'd0;
         al_mn_u <= 4'd0;
         a_out   <= 1'b0;
      end else begin
         hr_t <= nx_hr_t;
         hr_u <= nx_hr_u;
         mn_t <= nx_mn_t;
         mn_u <= nx_mn_u;
         sc_t <= nx_sc_t;
         sc_u <= nx_sc_u;
         if (set_any && alarm_ok) begin
            al_hr_t <= ain1[1:0];
            al_hr_u <= ain2[3:0];
            al_mn_t <= ain3[2:0];
            al_mn_u <= ain4[3:0];
         end
         if (clr_any || !en_any)
            a_out <= 1'b0;
         else if (trigger)
            a_out <= 1'b1;
      end
   end

   logic [4:0] hr_bin, disp_bin, disp_u;
   logic [2:0] disp_t;

   assign hr_bin = 5'(hr_t) * 5'd10 + 5'(hr_u);

   always_comb begin
      disp_bin = hr_bin;
      if (!hour_24) begin
         if (hr_bin == 5'd0)
            disp_bin = 5'd12;
         else if (hr_bin > 5'd12)
            disp_bin = hr_bin - 5'd12;
      end
      if (disp_bin >= 5'd20) begin
         disp_t = 3'd2;
         disp_u = disp_bin - 5'd20;
      end else if (disp_bin >= 5'd10) begin
         disp_t = 3'd1;
         disp_u = disp_bin - 5'd10;
      end else begin
         disp_t = 3'd0;
         disp_u = disp_bin;
      end
   end

   assign h1 = disp_t;
   assign h0 = disp_u;
   assign m1 = {1'b0, mn_t};
   assign m0 = {1'b0, mn_u};
   assign s1 = {1'b0, sc_t};
   assign s0 = {1'b0, sc_u};
   assign am = !hour_24 && (hr_bin < 5'd12);
   assign pm = !hour_24 && (hr_bin >= 5'd12);

`ifdef DE_STOPWATCH_EN
   logic running;

   always_ff @(posedge clk) begin
      if (r || restart) begin
         count   <= 32'd0;
         running <= 1'b0;
      end else if (pause) begin
         running <= 1'b0;
      end else begin
         if (start)
            running <= 1'b1;
         if (running)
            count <= count + 32'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_de_digital_clock.sv
// tb_de_digital_clock: directed self-checking bench for de_digital_clock.
`default_nettype none

module tb_de_digital_clock;

   logic        clk = 1'b0;
   logic        r = 1'b0, s = 1'b0, hour_24 = 1'b1;
   logic [2:0]  a = '0;
   logic [4:0]  b = '0;
   logic [3:0]  c = '0;
   logic [4:0]  d = '0;
   logic [3:0]  e = '0;
   logic [4:0]  f = '0;
   logic [2:0]  ain1 = '0;
   logic [4:0]  ain2 = '0;
   logic [3:0]  ain3 = '0;
   logic [4:0]  ain4 = '0;
   logic [2:0]  a_enable = '0, a_reset = '0, a_set = '0;
   logic [2:0]  h1;
   logic [4:0]  h0;
   logic [3:0]  m1;
   logic [4:0]  m0;
   logic [3:0]  s1;
   logic [4:0]  s0;
   logic        am, pm, a_out;
`ifdef DE_STOPWATCH_EN
   logic        start = 1'b0, pause = 1'b0, restart = 1'b0;
   logic [31:0] count;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   de_digital_clock dut (
      .clk(clk), .r(r), .s(s), .hour_24(hour_24),
      .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
      .ain1(ain1), .ain2(ain2), .ain3(ain3), .ain4(ain4),
      .a_enable(a_enable), .a_reset(a_reset), .a_set(a_set),
`ifdef DE_STOPWATCH_EN
      .start(start), .pause(pause), .restart(restart), .count(count),
`endif
      .h1(h1), .h0(h0), .m1(m1), .m0(m0), .s1(s1), .s0(s0),
      .am(am), .pm(pm), .a_out(a_out)
   );

   wire [25:0] disp = {h1, h0, m1, m0, s1, s0};

   function automatic logic [25:0] t(input int hh, input int mm, input int ss);
      return {3'(hh / 10), 5'(hh % 10), 4'(mm / 10), 5'(mm % 10), 4'(ss / 10), 5'(ss % 10)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int hh, input int mm, input int ss);
      a = 3'(hh / 10); b = 5'(hh % 10);
      c = 4'(mm / 10); d = 5'(mm % 10);
      e = 4'(ss / 10); f = 5'(ss % 10);
      s = 1'b1;
      tick();
      s = 1'b0;
   endtask

   task automatic test_reset();
      hour_24 = 1'b0;
      s = 1'b1; a = 3'd1;
      r = 1'b1;
      tick();
      r = 1'b0; s = 1'b0; a = '0;
      checks++;
      if (disp !== t(12, 0, 0)) begin errors++; $display("FAIL reset_12h disp got %h want %h", disp, t(12, 0, 0)); end
      checks++;
      if ({am, pm, a_out} !== 3'b100) begin errors++; $display("FAIL reset_flags am/pm/a_out got %b want 100", {am, pm, a_out}); end
      hour_24 = 1'b1; #1;
      checks++;
      if ({disp, am, pm} !== {t(0, 0, 0), 2'b00}) begin errors++; $display("FAIL reset_24h got %h %b%b want %h 00", disp, am, pm, t(0, 0, 0)); end
   endtask

   task automatic test_rollover();
      hour_24 = 1'b1;
      load(23, 59, 58);
      checks++;
      if (disp !== t(23, 59, 58)) begin errors++; $display("FAIL load_235958 got %h want %h", disp, t(23, 59, 58)); end
      tick();
      checks++;
      if (disp !== t(23, 59, 59)) begin errors++; $display("FAIL count_235959 got %h want %h", disp, t(23, 59, 59)); end
      hour_24 = 1'b0; #1;
      checks++;
      if ({disp, am, pm} !== {t(11, 59, 59), 2'b01}) begin errors++; $display("FAIL pm_115959 got %h %b%b want %h 01", disp, am, pm, t(11, 59, 59)); end
      tick();
      checks++;
      if ({disp, am, pm} !== {t(12, 0, 0), 2'b10}) begin errors++; $display("FAIL wrap_12am got %h %b%b want %h 10", disp, am, pm, t(12, 0, 0)); end
      hour_24 = 1'b1; #1;
      checks++;
      if (disp !== t(0, 0, 0)) begin errors++; $display("FAIL wrap_24h got %h want %h", disp, t(0, 0, 0)); end
      // midday and early afternoon in 12 h mode
      load(12, 0, 0);
      hour_24 = 1'b0; #1;
      checks++;
      if ({disp, am, pm} !== {t(12, 0, 0), 2'b01}) begin errors++; $display("FAIL noon got %h %b%b want %h 01", disp, am, pm, t(12, 0, 0)); end
      load(13, 5, 9);
      checks++;
      if ({disp, am, pm} !== {t(1, 5, 9), 2'b01}) begin errors++; $display("FAIL 13h got %h %b%b want %h 01", disp, am, pm, t(1, 5, 9)); end
      load(9, 59, 59);
      tick();
      hour_24 = 1'b1; #1;
      checks++;
      if (disp !== t(10, 0, 0)) begin errors++; $display("FAIL hour_carry got %h want %h", disp, t(10, 0, 0)); end
   endtask

   task automatic test_bad_load();
      hour_24 = 1'b1;
      load(5, 6, 7);
      a = 3'd2; b = 5'd5; c = '0; d = '0; e = '0; f = '0;
      s = 1'b1; tick(); s = 1'b0;
      checks++;
      if (disp !== t(5, 6, 8)) begin errors++; $display("FAIL reject_hour25 got %h want %h", disp, t(5, 6, 8)); end
      a = 3'd0; b = 5'd1; c = 4'd6; d = 5'd0;
      s = 1'b1; tick(); s = 1'b0;
      checks++;
      if (disp !== t(5, 6, 9)) begin errors++; $display("FAIL reject_min60 got %h want %h", disp, t(5, 6, 9)); end
      c = 4'd0; f = 5'd10;
      s = 1'b1; tick(); s = 1'b0;
      checks++;
      if (disp !== t(5, 6, 10)) begin errors++; $display("FAIL reject_sec_units got %h want %h", disp, t(5, 6, 10)); end
   endtask

   task automatic test_alarm();
      hour_24 = 1'b1;
      ain1 = 3'd0; ain2 = 5'd7; ain3 = 4'd3; ain4 = 5'd0;
      a_set = 3'b001; tick(); a_set = '0;
      a_enable = 3'b100;
      load(7, 29, 59);
      checks++;
      if (a_out !== 1'b0) begin errors++; $display("FAIL alarm_early a_out got %b want 0", a_out); end
      tick();
      checks++;
      if ({disp, a_out} !== {t(7, 30, 0), 1'b1}) begin errors++; $display("FAIL alarm_ring got %h %b want %h 1", disp, a_out, t(7, 30, 0)); end
      tick();
      checks++;
      if (a_out !== 1'b1) begin errors++; $display("FAIL alarm_hold a_out got %b want 1", a_out); end
      a_reset = 3'b010; tick(); a_reset = '0;
      checks++;
      if (a_out !== 1'b0) begin errors++; $display("FAIL alarm_clear a_out got %b want 0", a_out); end
      // an out-of-range alarm load must leave 07:30 in place
      ain2 = 5'd8; ain3 = 4'd6;
      a_set = 3'b111; tick(); a_set = '0;
      load(7, 29, 59);
      tick();
      checks++;
      if (a_out !== 1'b1) begin errors++; $display("FAIL alarm_reject a_out got %b want 1", a_out); end
      a_enable = '0; tick();
      checks++;
      if (a_out !== 1'b0) begin errors++; $display("FAIL alarm_disarm a_out got %b want 0", a_out); end
   endtask

   task automatic test_alarm_disabled();
      hour_24 = 1'b1;
      a_enable = '0;
      load(7, 29, 59);
      tick();
      checks++;
      if ({disp, a_out} !== {t(7, 30, 0), 1'b0}) begin errors++; $display("FAIL alarm_off got %h %b want %h 0", disp, a_out, t(7, 30, 0)); end
      a_enable = 3'b001;
      load(7, 29, 59);
      a_reset = 3'b001; tick(); a_reset = '0;
      checks++;
      if ({disp, a_out} !== {t(7, 30, 0), 1'b0}) begin errors++; $display("FAIL reset_wins got %h %b want %h 0", disp, a_out, t(7, 30, 0)); end
   endtask

   task automatic test_reset_mid_alarm();
      hour_24 = 1'b1;
      a_enable = 3'b001;
      load(7, 29, 59);
      tick();
      checks++;
      if (a_out !== 1'b1) begin errors++; $display("FAIL mid_ring a_out got %b want 1", a_out); end
      a = 3'd1; b = 5'd1; s = 1'b1;
      ain1 = 3'd1; ain2 = 5'd1; ain3 = 4'd0; ain4 = 5'd0; a_set = 3'b001;
      r = 1'b1; tick(); r = 1'b0; s = 1'b0; a_set = '0;
      checks++;
      if ({disp, a_out} !== {t(0, 0, 0), 1'b0}) begin errors++; $display("FAIL mid_reset got %h %b want %h 0", disp, a_out, t(0, 0, 0)); end
      // alarm register must now be 00:00
      load(23, 59, 59);
      tick();
      checks++;
      if ({disp, a_out} !== {t(0, 0, 0), 1'b1}) begin errors++; $display("FAIL alarm_cleared got %h %b want %h 1", disp, a_out, t(0, 0, 0)); end
      a_enable = '0; tick();
   endtask

`ifdef DE_STOPWATCH_EN
   task automatic test_stopwatch();
      r = 1'b1; tick(); r = 1'b0;
      checks++;
      if (count !== 32'd0) begin errors++; $display("FAIL sw_reset count got %0d want 0", count); end
      start = 1'b1; tick(); start = 1'b0;
      repeat (5) tick();
      checks++;
      if (count !== 32'd5) begin errors++; $display("FAIL sw_run count got %0d want 5", count); end
      pause = 1'b1; repeat (3) tick(); pause = 1'b0;
      checks++;
      if (count !== 32'd5) begin errors++; $display("FAIL sw_pause count got %0d want 5", count); end
      restart = 1'b1; tick(); restart = 1'b0;
      checks++;
      if (count !== 32'd0) begin errors++; $display("FAIL sw_restart count got %0d want 0", count); end
      tick();
      checks++;
      if (count !== 32'd0) begin errors++; $display("FAIL sw_stopped count got %0d want 0", count); end
   endtask
`endif

   initial begin
      #2;
      test_reset();
      test_rollover();
      test_bad_load();
      test_alarm();
      test_alarm_disabled();
      test_reset_mid_alarm();
`ifdef DE_STOPWATCH_EN
      test_stopwatch();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
